ps2_kbd_ctrl: RTL and testbench

Controller that sequences the ps2_rx receiver and turns its raw byte stream into keyboard key events. It gates the receiver via rx_en and decodes the scan-code set 2 prefixes E0 (extended) and F0 (break). Decoded events are buffered in a small FIFO and presented to the processor-side consumer through a valid/ready handshake. It sits between ps2_rx and the processor's memory-mapped keyboard register.

---
 rtl/ps2_kbd_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_ctrl.sv
// ============================================================================
//  Module   : ps2_kbd_ctrl
//  Brief    : Turns the ps2_rx byte stream into scan-code set 2 key events
//             (E0/F0 prefix decode) and buffers them for a valid/ready reader.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_kbd_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          rx_done_tick,
    input  logic [7:0]                    rx_data,
    output logic                          rx_en,
    output logic                          key_valid,
    output logic [7:0]                    key_code,
    output logic                          key_ext,
    output logic                          key_break,
    input  logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          kb_err,
    input  logic                          clr_flags
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(FIFO_DEPTH);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t            r_state;
    logic [c_TW-1:0]   r_timer;

    logic [9:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;
    logic [9:0]        r_head;
    logic              r_valid;
    logic              r_overflow;
    logic              r_kb_err;
    logic              r_rx_en;

    logic              w_tick;
    logic              w_e0;
    logic              w_f0;
    logic              w_bad;
    logic              w_ack;
    logic              w_push;
    logic              w_push_ext;
    logic              w_push_brk;
    logic              w_err_set;
    logic [9:0]        w_push_data;
    logic              w_pop;
    logic              w_full;
    logic              w_push_ok;
    logic              w_ovf_set;
    logic [c_AW-1:0]   w_rd_next;

    assign w_tick = rx_done_tick & enable;
    assign w_e0   = (rx_data == 8'hE0);
    assign w_f0   = (rx_data == 8'hF0);
    assign w_bad  = (rx_data == 8'h00) || (rx_data == 8'hFF);
    // Keyboard status/acknowledge bytes and the Pause prefix never form key events.
    assign w_ack  = (rx_data == 8'hE1) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                    (rx_data == 8'hAA) || (rx_data == 8'hEE);

    always_comb begin
        w_push     = 1'b0;
        w_push_ext = 1'b0;
        w_push_brk = 1'b0;
        w_err_set  = 1'b0;
        if (w_tick) begin
            if (w_bad) begin
                w_err_set = 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_push = !(w_e0 || w_f0 || w_ack);
                    end
                    S_EXT: begin
                        w_push     = !(w_e0 || w_f0);
                        w_push_ext = 1'b1;
                    end
                    S_BRK: begin
                        w_push     = !(w_e0 || w_f0);
                        w_push_brk = 1'b1;
                    end
                    default: begin
                        w_push     = !(w_e0 || w_f0);
                        w_push_ext = 1'b1;
                        w_push_brk = 1'b1;
                    end
                endcase
            end
        end
    end

    assign w_push_data = {w_push_ext, w_push_brk, rx_data};

    // Prefix tracking; the timer restarts whenever a prefix byte is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else if (!enable) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_e0)      r_state <= S_EXT;
                    else if (w_f0) r_state <= S_BRK;
                end
                S_EXT: begin
                    if (w_f0)      r_state <= S_EXT_BRK;
                    else if (!w_e0) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end else if (r_state != S_IDLE) begin
            if (r_timer == c_TMAX) begin
                r_state <= S_IDLE;
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    assign w_pop     = r_valid & key_ready;
    assign w_full    = (r_count == c_FULL);
    assign w_push_ok = w_push & (!w_full | w_pop);
    assign w_ovf_set = w_push & w_full & !w_pop;
    assign w_rd_next = r_rd_ptr + c_AW'(1);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Head event is registered so outputs hold their last value once drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)     r_rd_ptr <= w_rd_next;

            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (r_count == '0) begin
                if (w_push_ok) begin
                    r_head  <= w_push_data;
                    r_valid <= 1'b1;
                end
            end else if (w_pop) begin
                if (r_count == c_CW'(1)) begin
                    if (w_push_ok) r_head <= w_push_data;
                    else           r_valid <= 1'b0;
                end else begin
                    r_head <= r_mem[w_rd_next];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_kb_err   <= 1'b0;
            r_rx_en    <= 1'b0;
        end else begin
            r_overflow <= w_ovf_set | (r_overflow & ~clr_flags);
            r_kb_err   <= w_err_set | (r_kb_err & ~clr_flags);
            r_rx_en    <= enable & (r_count != c_FULL);
        end
    end

    assign rx_en      = r_rx_en;
    assign key_valid  = r_valid;
    assign key_ext    = r_head[9];
    assign key_break  = r_head[8];
    assign key_code   = r_head[7:0];
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign kb_err     = r_kb_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_ctrl.sv
// ============================================================================
//  Module   : tb_ps2_kbd_ctrl
//  Brief    : Randomised + directed bench for ps2_kbd_ctrl with a queue-based
//             reference model and a negedge monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       kb_err;
    logic       clr_flags;

    ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .rx_en        (rx_en),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_ext      (key_ext),
        .key_break    (key_break),
        .key_ready    (key_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .kb_err       (kb_err),
        .clr_flags    (clr_flags)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents as a queue of {ext,brk,code},
    // pending prefix bytes as a queue, timeout by edge arithmetic.
    logic [9:0] m_q[$];
    logic [7:0] m_pend[$];
    logic [9:0] m_hold = '0;
    logic       m_ovf  = 1'b0;
    logic       m_err  = 1'b0;
    logic       m_rxen = 1'b0;
    int         m_cyc  = 0;
    int         m_last = 0;

    function automatic bit is_ack(input logic [7:0] b);
        return (b == 8'hE1) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hAA) || (b == 8'hEE);
    endfunction

    always @(posedge clk or negedge reset) begin
        bit         pop, push, err_set, ovf_set;
        int         sz;
        logic [9:0] ev;
        logic [7:0] b;
        if (!reset) begin
            m_q.delete();
            m_pend.delete();
            m_hold = '0;
            m_ovf  = 1'b0;
            m_err  = 1'b0;
            m_rxen = 1'b0;
            m_cyc  = 0;
        end else begin
            m_cyc++;
            sz      = m_q.size();
            pop     = (sz > 0) && key_ready;
            push    = 1'b0;
            err_set = 1'b0;
            ovf_set = 1'b0;
            ev      = '0;
            b       = rx_data;
            m_rxen  = enable && (sz != DEPTH);
            if (!enable) begin
                m_pend.delete();
            end else if (rx_done_tick) begin
                if (m_pend.size() > 0 && (m_cyc - m_last) > TMO) m_pend.delete();
                if (b == 8'h00 || b == 8'hFF) begin
                    err_set = 1'b1;
                    m_pend.delete();
                end else if (m_pend.size() == 0) begin
                    if (b == 8'hE0 || b == 8'hF0) begin
                        m_pend.push_back(b);
                        m_last = m_cyc;
                    end else if (!is_ack(b)) begin
                        push = 1'b1;
                        ev   = {2'b00, b};
                    end
                end else if (m_pend[m_pend.size()-1] == 8'hE0) begin
                    if (b == 8'hF0) begin
                        m_pend.push_back(b);
                        m_last = m_cyc;
                    end else if (b == 8'hE0) begin
                        m_last = m_cyc;
                    end else begin
                        push = 1'b1;
                        ev   = {2'b10, b};
                        m_pend.delete();
                    end
                end else begin
                    if (b != 8'hE0 && b != 8'hF0) begin
                        push = 1'b1;
                        ev   = {(m_pend[0] == 8'hE0), 1'b1, b};
                    end
                    m_pend.delete();
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                if (sz < DEPTH || pop) m_q.push_back(ev);
                else                   ovf_set = 1'b1;
            end
            if (m_q.size() > 0) m_hold = m_q[0];
            m_ovf = ovf_set | (m_ovf & ~clr_flags);
            m_err = err_set | (m_err & ~clr_flags);
        end
    end

    // Monitor: compares every DUT output against the model away from the edge.
    always @(negedge clk) begin
        chk("key_valid",  {31'd0, key_valid}, {31'd0, (m_q.size() > 0)});
        chk("fifo_count", {29'd0, fifo_count}, m_q.size());
        if (m_q.size() > 0) chk("head_event", {22'd0, key_ext, key_break, key_code}, {22'd0, m_q[0]});
        else                chk("held_event", {22'd0, key_ext, key_break, key_code}, {22'd0, m_hold});
        chk("overflow",   {31'd0, overflow}, {31'd0, m_ovf});
        chk("kb_err",     {31'd0, kb_err},   {31'd0, m_err});
        chk("rx_en",      {31'd0, rx_en},    {31'd0, m_rxen});
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_done_tick = 1'b1;
        rx_data      = b;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1 clr_flags = 1'b1;
        @(posedge clk);
        #1 clr_flags = 1'b0;
    endtask

    logic [7:0] ack_set [5] = '{8'hE1, 8'hFA, 8'hFE, 8'hAA, 8'hEE};

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom % 16;
        if (r < 3)       return 8'hE0;
        else if (r < 6)  return 8'hF0;
        else if (r == 6) return ($urandom % 2) ? 8'hFF : 8'h00;
        else if (r == 7) return ack_set[$urandom % 5];
        else             return 8'($urandom);
    endfunction

    initial begin
        reset        = 1'b0;
        enable       = 1'b0;
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
        key_ready    = 1'b0;
        clr_flags    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b1;
        idle(2);

        // Single make code
        send(8'h1C);
        chk("t1_valid", {31'd0, key_valid}, 32'd1);
        chk("t1_code",  {24'd0, key_code}, 32'h1C);
        chk("t1_count", {29'd0, fifo_count}, 32'd1);
        chk("t1_rx_en", {31'd0, rx_en}, 32'd1);

        // Prefix sequences
        send(8'hF0); send(8'h1C);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h75);
        chk("t2_count", {29'd0, fifo_count}, 32'd4);
        key_ready = 1'b1;
        idle(6);
        key_ready = 1'b0;

        // Overflow and drain
        send(8'h15); send(8'h16); send(8'h17); send(8'h18); send(8'h19);
        idle(1);
        chk("t3_count",    {29'd0, fifo_count}, 32'd4);
        chk("t3_rx_en",    {31'd0, rx_en}, 32'd0);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        key_ready = 1'b1;
        idle(6);
        key_ready = 1'b0;
        pulse_clr();

        // Full FIFO with simultaneous push and pop
        send(8'h20); send(8'h21); send(8'h22); send(8'h23);
        @(posedge clk);
        #1;
        key_ready    = 1'b1;
        rx_done_tick = 1'b1;
        rx_data      = 8'h1A;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        key_ready    = 1'b0;
        chk("t4_count",    {29'd0, fifo_count}, 32'd4);
        chk("t4_overflow", {31'd0, overflow}, 32'd0);
        key_ready = 1'b1;
        idle(6);
        key_ready = 1'b0;

        // Prefix timeout: long gap, short gap, and both sides of the boundary
        send(8'hF0); idle(150); send(8'h1C);
        send(8'hF0); idle(50);  send(8'h1C);
        send(8'hF0); idle(98);  send(8'h2A);
        send(8'hF0); idle(99);  send(8'h2B);
        key_ready = 1'b1;
        idle(6);
        key_ready = 1'b0;

        // Error byte, flag clear, async reset mid-sequence
        send(8'hFF);
        chk("t6_kb_err", {31'd0, kb_err}, 32'd1);
        pulse_clr();
        chk("t6_kb_clr", {31'd0, kb_err}, 32'd0);
        send(8'h31); send(8'h32); send(8'hE0);
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        chk("rst_head",  {22'd0, key_ext, key_break, key_code}, 32'd0);
        chk("rst_rx_en", {31'd0, rx_en}, 32'd0);
        idle(2);
        reset = 1'b1;
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom % 150 == 0) begin
                rx_done_tick = 1'b0;
                repeat (95 + ($urandom % 10)) @(posedge clk);
            end
            @(posedge clk);
            #1;
            rx_done_tick = ($urandom % 3 == 0);
            rx_data      = pick_byte();
            key_ready    = ((i / 250) % 2 == 0) ? ($urandom % 4 != 0) : ($urandom % 6 == 0);
            enable       = ($urandom % 60 != 0);
            clr_flags    = ($urandom % 50 == 0);
        end
        rx_done_tick = 1'b0;
        clr_flags    = 1'b0;
        enable       = 1'b1;
        key_ready    = 1'b1;
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
